// File: rtl/tankwar_pkg.sv
// Shared playfield codes for the tank game: movement directions, renderer
// categories and the bullet sweep states.
package tankwar_pkg;

  typedef enum logic [1:0] {
    DIR_LEFT  = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_UP    = 2'd2,
    DIR_DOWN  = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    CAT_NONE   = 2'd0,
    CAT_WALL   = 2'd1,
    CAT_TANK   = 2'd2,
    CAT_BULLET = 2'd3
  } cat_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } sweep_state_e;

endpackage

// File: rtl/bullet_step.sv
// One-block move of a SIZE x SIZE object; flags moves that would leave the field.
// Bounds are tested before the add/subtract, so coordinates never wrap.
module bullet_step
  import tankwar_pkg::*;
#(
  parameter int CW      = 10,
  parameter int FIELD_W = 60,
  parameter int FIELD_H = 45,
  parameter int SIZE    = 1
) (
  input  logic [CW-1:0] x,
  input  logic [CW-1:0] y,
  input  dir_e          dir,
  output logic [CW-1:0] nx,
  output logic [CW-1:0] ny,
  output logic          off_field
);

  logic [CW:0] right_edge, bottom_edge;

  // Far edge of the object, one bit wider so x+SIZE cannot overflow.
  assign right_edge  = {1'b0, x} + (CW+1)'(SIZE);
  assign bottom_edge = {1'b0, y} + (CW+1)'(SIZE);

  always_comb begin
    nx        = x;
    ny        = y;
    off_field = 1'b0;
    case (dir)
      DIR_LEFT:  if (x == '0) off_field = 1'b1; else nx = x - 1'b1;
      DIR_RIGHT: if (right_edge >= (CW+1)'(FIELD_W)) off_field = 1'b1; else nx = x + 1'b1;
      DIR_UP:    if (y == '0) off_field = 1'b1; else ny = y - 1'b1;
      default:   if (bottom_edge >= (CW+1)'(FIELD_H)) off_field = 1'b1; else ny = y + 1'b1;
    endcase
  end

endmodule

// File: rtl/bullet_engine.sv
// Bullet slot pool with spawn handshake, tick-driven one-slot-per-cycle move sweep
// and registered block-occupancy query. Target-box retirement under BULLET_HIT_CHECK_EN.
module bullet_engine
  import tankwar_pkg::*;
#(
  parameter int MAX_BULLETS = 16,
  parameter int FIELD_W     = 60,
  parameter int FIELD_H     = 45,
  parameter int CW          = 10,
  parameter int TGT_SIZE    = 3,
  localparam int IW         = $clog2(MAX_BULLETS),
  localparam int NW         = $clog2(MAX_BULLETS+1)
) (
  input  logic          clk_100mhz,
  input  logic          rst,
  input  logic          tick,
  input  logic          spawn_valid,
  output logic          spawn_ready,
  input  logic [CW-1:0] spawn_x,
  input  logic [CW-1:0] spawn_y,
  input  logic [1:0]    spawn_dir,
  input  logic [CW-1:0] tgt_x,
  input  logic [CW-1:0] tgt_y,
  output logic          hit,
  output logic [IW-1:0] hit_slot,
  output logic          busy,
  output logic [NW-1:0] count,
  output logic          tick_overrun,
  input  logic [CW-1:0] query_x,
  input  logic [CW-1:0] query_y,
  output logic          query_hit
);

  sweep_state_e                     state_q, state_d;
  logic [IW-1:0]                    ptr_q, ptr_d;
  logic [MAX_BULLETS-1:0]           valid_q, valid_d;
  logic [MAX_BULLETS-1:0][CW-1:0]   x_q, x_d, y_q, y_d;
  logic [MAX_BULLETS-1:0][1:0]      dir_q, dir_d;
  logic [NW-1:0]                    count_q, count_d;
  logic                             overrun_q, overrun_d;
  logic                             query_hit_q, query_hit_d;
  logic [MAX_BULLETS-1:0]           qmatch;
  logic [IW-1:0]                    free_idx;
  logic [CW-1:0]                    nx, ny;
  logic                             off_field, spawn_in_field;

  bullet_step #(.CW(CW), .FIELD_W(FIELD_W), .FIELD_H(FIELD_H), .SIZE(1)) u_step (
    .x(x_q[ptr_q]), .y(y_q[ptr_q]), .dir(dir_e'(dir_q[ptr_q])),
    .nx(nx), .ny(ny), .off_field(off_field)
  );

  genvar g;
  generate
    for (g = 0; g < MAX_BULLETS; g++) begin : g_q
      assign qmatch[g] = valid_q[g] && (x_q[g] == query_x) && (y_q[g] == query_y);
    end
  endgenerate

  always_comb begin
    free_idx = '0;
    for (int i = MAX_BULLETS-1; i >= 0; i--)
      if (!valid_q[i]) free_idx = IW'(i);
  end

  assign spawn_ready    = (state_q == ST_IDLE) && !(&valid_q);
  assign spawn_in_field = (spawn_x < CW'(FIELD_W)) && (spawn_y < CW'(FIELD_H));
  assign query_hit_d    = |qmatch;

`ifdef BULLET_HIT_CHECK_EN
  logic          hit_q, hit_d;
  logic [IW-1:0] hit_slot_q, hit_slot_d;
  logic          in_box;
  assign in_box = ({1'b0, nx} >= {1'b0, tgt_x}) && ({1'b0, nx} < {1'b0, tgt_x} + (CW+1)'(TGT_SIZE)) &&
                  ({1'b0, ny} >= {1'b0, tgt_y}) && ({1'b0, ny} < {1'b0, tgt_y} + (CW+1)'(TGT_SIZE));
`else
  logic unused_tgt;
  assign unused_tgt = ^{tgt_x, tgt_y};
`endif

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    valid_d   = valid_q;
    x_d       = x_q;
    y_d       = y_q;
    dir_d     = dir_q;
    count_d   = count_q;
    overrun_d = 1'b0;
`ifdef BULLET_HIT_CHECK_EN
    hit_d      = 1'b0;
    hit_slot_d = hit_slot_q;
`endif
    case (state_q)
      ST_IDLE: begin
        // Out-of-field spawns complete the handshake but never take a slot.
        if (spawn_valid && spawn_ready && spawn_in_field) begin
          valid_d[free_idx] = 1'b1;
          x_d[free_idx]     = spawn_x;
          y_d[free_idx]     = spawn_y;
          dir_d[free_idx]   = spawn_dir;
          count_d           = count_q + 1'b1;
        end
        if (tick) begin
          state_d = ST_SWEEP;
          ptr_d   = '0;
        end
      end
      default: begin
        if (valid_q[ptr_q]) begin
          if (off_field) begin
            valid_d[ptr_q] = 1'b0;
            count_d        = count_q - 1'b1;
          end else begin
            x_d[ptr_q] = nx;
            y_d[ptr_q] = ny;
`ifdef BULLET_HIT_CHECK_EN
            if (in_box) begin
              valid_d[ptr_q] = 1'b0;
              count_d        = count_q - 1'b1;
              hit_d          = 1'b1;
              hit_slot_d     = ptr_q;
            end
`endif
          end
        end
        if (tick) overrun_d = 1'b1;
        if (ptr_q == IW'(MAX_BULLETS-1)) begin
          state_d = ST_IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      valid_q     <= '0;
      x_q         <= '0;
      y_q         <= '0;
      dir_q       <= '0;
      count_q     <= '0;
      overrun_q   <= 1'b0;
      query_hit_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      valid_q     <= valid_d;
      x_q         <= x_d;
      y_q         <= y_d;
      dir_q       <= dir_d;
      count_q     <= count_d;
      overrun_q   <= overrun_d;
      query_hit_q <= query_hit_d;
    end
  end

`ifdef BULLET_HIT_CHECK_EN
  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      hit_q      <= 1'b0;
      hit_slot_q <= '0;
    end else begin
      hit_q      <= hit_d;
      hit_slot_q <= hit_slot_d;
    end
  end
  assign hit      = hit_q;
  assign hit_slot = hit_slot_q;
`else
  assign hit      = 1'b0;
  assign hit_slot = '0;
`endif

  assign busy         = (state_q == ST_SWEEP);
  assign count        = count_q;
  assign tick_overrun = overrun_q;
  assign query_hit    = query_hit_q;

endmodule

// File: doc/bullet_engine.md
Name: bullet_engine

Overview:
Parametrised bullet store and mover for the tank playfield. It replaces the fixed 10-entry inline bullet arrays with a valid-bit slot pool and a spawn handshake. A tick-driven sequential sweep moves each bullet, retires bullets that leave the field, and optionally retires bullets that hit a target box. It also exposes a registered per-block occupancy query for the renderer's category mux.

Parameters:
MAX_BULLETS, 16, number of bullet slots (2..64)
FIELD_W, 60, playfield width in blocks
FIELD_H, 45, playfield height in blocks
CW, 10, coordinate width in bits
TGT_SIZE, 3, target box edge length in blocks (tank footprint)

Ports:
clk_100mhz  in  1  system clock
rst  in  1  asynchronous reset, active-high
tick  in  1  single-cycle move strobe (synchronised 250 ms edge)
spawn_valid  in  1  spawn request
spawn_ready  out  1  spawn can be accepted this cycle
spawn_x  in  CW  spawn column
spawn_y  in  CW  spawn row
spawn_dir  in  2  0=LEFT 1=RIGHT 2=UP 3=DOWN
tgt_x  in  CW  target box left column
tgt_y  in  CW  target box top row
hit  out  1  one-cycle pulse: bullet retired on target
hit_slot  out  clog2(MAX_BULLETS)  slot index of the hit
busy  out  1  sweep in progress
count  out  clog2(MAX_BULLETS+1)  number of live bullets
tick_overrun  out  1  one-cycle pulse: tick dropped during sweep
query_x  in  CW  block column to test
query_y  in  CW  block row to test
query_hit  out  1  a live bullet occupies (query_x,query_y); 1-cycle latency

Behaviour:
- Reset (async): all valid bits 0, state IDLE, ptr 0, count 0; hit, busy, tick_overrun and query_hit 0. spawn_ready reads 1 immediately after reset release.
- State machine IDLE/SWEEP.
  - IDLE: a tick moves to SWEEP with ptr=0.
  - SWEEP: processes slot ptr each cycle. ptr==MAX_BULLETS-1 returns to IDLE.
  - A sweep always takes exactly MAX_BULLETS cycles. busy=1 throughout SWEEP.
- Slot processing:
  - Invalid slot: no-op.
  - Valid slot: compute the next position one block in dir.
  - Move off-field (LEFT at x==0, RIGHT at x==FIELD_W-1, UP at y==0, DOWN at y==FIELD_H-1): clear valid, position unchanged.
  - Otherwise: write the next position.
- Spawn:
  - spawn_ready = (state==IDLE) & (any slot free).
  - On transfer, write the lowest-index free slot and set valid.
  - spawn_x>=FIELD_W or spawn_y>=FIELD_H: transfer is accepted and dropped; no slot consumed, count unchanged.
- Spawn and tick in the same cycle: the spawn is written, the sweep starts, and the new bullet moves in that sweep.
- Tick while in SWEEP: ignored; tick_overrun pulses.
- count updates on the same edge as the valid change. Multiple changes in one cycle are impossible (spawn only in IDLE, retire only in SWEEP).
- Full pool (count==MAX_BULLETS): spawn_ready=0; the requester holds or withdraws.
- query_hit: registered OR over all valid slots of (x==query_x & y==query_y).
- Arithmetic is unsigned CW-bit. Bounds checks happen before increment/decrement, so there is no wrap-around.

Optional Feature:
BULLET_HIT_CHECK_EN
- Defined: after a move that stays on-field, if the new position lies in [tgt_x, tgt_x+TGT_SIZE-1] x [tgt_y, tgt_y+TGT_SIZE-1], the slot is cleared, count decrements, hit pulses next cycle and hit_slot = slot index. tgt_* are sampled per processed slot.
- Undefined: tgt_x/tgt_y are ignored, hit and hit_slot are tied 0, and no hit logic is synthesised.

Decomposition:
- Shared package tankwar_pkg: direction codes LEFT/RIGHT/UP/DOWN (2-bit) and category codes NONE/WALL/TANK/BULLET.
- Sub-module bullet_step (combinational): inputs x, y, dir; outputs nx, ny, off_field. It is reused later for enemy tank movement with an edge-size parameter.

Test Plan:
1. Reset, spawn (5,5,RIGHT), 3 ticks -> slot0 at (8,5), count=1; query (8,5) -> query_hit=1 one cycle after the query is applied.
2. Spawn (0,10,LEFT), tick -> slot retired, count 1->0 at the edge of its processed cycle, busy high exactly 16 cycles.
3. Fill 16 spawns -> spawn_ready=0 at count=16; the 17th request is held unaccepted until a tick retires a bullet.
4. Tick, then a second tick at sweep cycle 4 -> tick_overrun pulses once, exactly one sweep occurs, spawn_ready=0 during the sweep.
5. With BULLET_HIT_CHECK_EN, tgt=(10,10), spawn (8,11,RIGHT), 2 ticks -> second tick: hit=1 with hit_slot=0, count=0; without the macro the bullet ends at (10,11), hit stays 0.
6. Assert rst mid-sweep -> all outputs return to reset values asynchronously, count=0, no hit pulse after release.
